// File: rtl/io_sync_debounce.sv
// Board input conditioning: multi-stage synchronisers for switches and buttons,
// counter-based button debounce, registered press/release pulses and sticky press latches.
module io_sync_debounce #(
  parameter int SW_W        = 32,
  parameter int BTN_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  input  logic [BTN_W-1:0] i_clr,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_btn_level,
  output logic [BTN_W-1:0] o_btn_press,
  output logic [BTN_W-1:0] o_btn_release,
  output logic [BTN_W-1:0] o_btn_sticky
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Stage 0 is the metastability-exposed flop; the last stage is the clean copy.
  logic [SYNC_STAGES-1:0][SW_W-1:0]  sw_sync_q;
  logic [SYNC_STAGES-1:0][BTN_W-1:0] btn_sync_q;
  logic [BTN_W-1:0]                  btn_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync_q  <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], i_io_sw};
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], i_io_btn};
    end
  end

  assign btn_s   = btn_sync_q[SYNC_STAGES-1];
  assign o_io_sw = sw_sync_q[SYNC_STAGES-1];

  logic [BTN_W-1:0] level_q, level_d;
  logic [BTN_W-1:0] press_q, press_d;
  logic [BTN_W-1:0] release_q, release_d;
  logic [BTN_W-1:0] sticky_q, sticky_d;

  genvar gi;
  generate
    for (gi = 0; gi < BTN_W; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_d;
      logic             upd;

      // Any cycle where the synchronised input agrees with the level restarts the count.
      always_comb begin
        cnt_d = '0;
        lvl_d = level_q[gi];
        upd   = 1'b0;
        if (btn_s[gi] != level_q[gi]) begin
          if (cnt_q == CNT_MAX) begin
            lvl_d = btn_s[gi];
            upd   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign level_d[gi]   = lvl_d;
      assign press_d[gi]   = upd & btn_s[gi];
      assign release_d[gi] = upd & ~btn_s[gi];
    end
  endgenerate

  // A press landing in the same cycle as a clear keeps the latch set.
  assign sticky_d = (sticky_q & ~i_clr) | press_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      sticky_q  <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o_btn_level   = level_q;
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;
  assign o_btn_sticky  = sticky_q;

endmodule

// File: doc/io_sync_debounce.md
# io_sync_debounce

Parametrised input-conditioning stage for the processor's board I/O. It replaces the single flip-flop input register in front of the processor core with three functions: an N-stage synchroniser for switches, per-button counter-based debounce, and registered press/release edge pulses with sticky press latches that software can clear. It sits between the board pins and the processor's `i_io_sw` / `i_io_btn` inputs.

## Interface
- `SW_W`, 32: switch channel count.
- `BTN_W`, 4: button channel count.
- `SYNC_STAGES`, 2: synchroniser depth, legal range ≥2.
- `DB_CYCLES`, 16: consecutive stable synchronised cycles needed to accept a button change, legal range ≥1.
- Internal counter width is `CNT_W = max(1, $clog2(DB_CYCLES))`.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_io_sw` in SW_W: raw switches, asynchronous.
- `i_io_btn` in BTN_W: raw buttons, asynchronous, active-high meaning pressed.
- `i_clr` in BTN_W: synchronous per-bit clear of `o_btn_sticky`.
- `o_io_sw` out SW_W: synchronised switches.
- `o_btn_level` out BTN_W: debounced button level.
- `o_btn_press` out BTN_W: one-cycle pulse on a debounced 0→1 change.
- `o_btn_release` out BTN_W: one-cycle pulse on a debounced 1→0 change.
- `o_btn_sticky` out BTN_W: latched press, held until cleared.

## Operation
- **Synchroniser.** Every switch and button bit passes through a `SYNC_STAGES`-deep flip-flop chain. `o_io_sw` is the last stage of its chain. Call the last stage of button chain `b` `s[b]`.
- **Debounce, per button `b`.** State is `level[b]` and `cnt[b]`.
  - `s[b] == level[b]`: `cnt` ← 0.
  - `s[b] != level[b]` and `cnt < DB_CYCLES-1`: `cnt` ← `cnt+1`.
  - `s[b] != level[b]` and `cnt == DB_CYCLES-1`: `level` ← `s`, `cnt` ← 0. This is the update event.
  - The counter never wraps. Any cycle where `s` matches `level` restarts the count.
- **Edge pulses.**
  - `o_btn_press[b]` ← update event with `s[b] == 1`.
  - `o_btn_release[b]` ← update event with `s[b] == 0`.
  - Both are registered. Each pulse is high exactly in the first cycle the new `o_btn_level` value is visible.
- **Sticky latch.** `sticky` ← `(sticky & ~i_clr) | press_next`. If a set and a clear land in the same cycle, set wins. Bits are fully independent.
- Channels never interact. All state is per bit.

## Timing
- **Reset.** Every flip-flop, and therefore every output, goes to 0 immediately on `i_rst_n` low, regardless of clock.
- **Out of reset.** Release of reset with a button held produces a normal press sequence after the full latency. No pulse is produced by the reset edge itself.
- **Switch latency.** A raw change sampled at edge k appears on `o_io_sw` after edge k+SYNC_STAGES-1 (`SYNC_STAGES` cycles).
- **Button latency.** A raw change held stable from edge k appears on `o_btn_level` and the pulse outputs after edge k+SYNC_STAGES+DB_CYCLES-1.
  - Example, SYNC_STAGES=2 and DB_CYCLES=16: 18 cycles.
  - Example, DB_CYCLES=1: level follows `s` with 1 cycle delay.
- **Glitch rejection.** A synchronised excursion shorter than `DB_CYCLES` cycles produces no level change and no pulse.
- **Pulse width.** Pulses are exactly 1 cycle. Press and release for the same bit are never high together.
- **Mid-operation reset.** A reset during a count discards the count. No pulse is emitted during reset or in the first cycle after it.

## Test plan
- **Reset mid-operation.** Hold `i_io_btn=4'hF` and `i_io_sw=32'hFFFF_FFFF` for 40 cycles, then drive `i_rst_n` low asynchronously between edges.
  - All outputs read 0 before the next edge.
  - After release: `o_btn_level=4'hF` and `o_btn_press=4'hF` appear together exactly 18 cycles later, and press lasts 1 cycle.
- **Switch synchroniser.** Drive `i_io_sw=32'hA5A5_0F0F` before edge 0.
  - `o_io_sw` still reads the old value after edge 0.
  - It reads `32'hA5A5_0F0F` after edge 1.
- **Bounce.** Toggle `btn[0]` every 3 cycles for 30 cycles, then hold it at 1.
  - `o_btn_level[0]` rises 18 cycles after the final 0→1 raw edge.
  - Exactly one `o_btn_press[0]` pulse is produced, and zero release pulses.
- **Glitch and release.** With level=1, pull `btn[1]` low for 15 cycles: no change, no pulses. Then pull it low and hold.
  - After 18 cycles: `o_btn_level[1]=0`.
  - Exactly one 1-cycle `o_btn_release[1]` pulse is produced.
- **Sticky latch.** Press `btn[2]`.
  - `o_btn_sticky[2]=1` and stays 1 after the button is released.
  - `i_clr=4'b0100` pulsed in the same cycle as a new press pulse leaves it at 1.
  - `i_clr=4'b0100` alone makes it 0 on the next edge.
  - `o_btn_sticky[3:0]` other bits are unchanged throughout.
- **DB_CYCLES=1, SYNC_STAGES=3.** A raw step on `btn[3]` appears on `o_btn_level[3]` exactly 4 cycles later, with a 1-cycle press pulse.
